card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
- Upstream card source for the blackjack controller.
- Models one 52-card deck without replacement and deals one card per request.
- Cards are picked pseudo-randomly from a 16-bit LFSR loaded from the 6-bit seed switches.
- The controller raises deal_req and consumes card_rank/card_suit on the card_valid pulse; rank encoding is 1=A, 2..10, 11=J, 12=Q, 13=K.

Parameters:
- SEED_W, 6: width of seed input.
- LFSR_W, 16: LFSR width.
- LFSR_PAD, 10'h2B3: constant low bits concatenated below seed at load; keeps the LFSR nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- new_deck  in  1  restore full deck and reload LFSR from seed (1-cycle level sample)
- seed  in  SEED_W  shuffle seed, sampled on reset/new_deck
- deal_req  in  1  request one card; sampled only in IDLE
- card_valid  out  1  one-cycle pulse; card outputs valid this cycle
- card_rank  out  4  1..13; holds last dealt value
- card_suit  out  2  0..3; holds last dealt value
- busy  out  1  high from accept until card_valid cycle inclusive
- deal_err  out  1  one-cycle pulse: request while deck empty
- cards_left  out  6  cards remaining, 52..0
- deck_empty  out  1  cards_left==0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst.
- Reset (rst==0 at a clk edge): state=IDLE, used[51:0]=0, cards_left=52, lfsr={seed,LFSR_PAD}. card_valid, deal_err, busy = 0; card_rank=0, card_suit=0.
- LFSR:
  - Fibonacci, shift left, fb = l[15]^l[13]^l[12]^l[10].
  - Steps every cycle except the reload cycle.
- Index reduction: r = lfsr[5:0]; idx = (r>=52) ? r-52 : r.
- Card decode from index i: suit = i/13, rank = (i mod 13)+1.
- Priority per edge: rst > new_deck > FSM.
- new_deck:
  - Same effect as reset on used, cards_left, lfsr, state; card_valid and deal_err forced 0.
  - Card outputs are held.
  - An in-flight deal is aborted and never produces card_valid.
  - A simultaneous deal_req is dropped.
- FSM states IDLE, PROBE, DELIVER.
- IDLE:
  - deal_req && !deck_empty: load probe index = idx(current lfsr), busy=1, go PROBE.
  - deal_req && deck_empty: deal_err=1 for one cycle, stay IDLE.
- PROBE:
  - If used[probe]==0: set used[probe], latch rank/suit, decrement cards_left, go DELIVER.
  - Else probe = (probe==51) ? 0 : probe+1 and stay PROBE.
  - Linear probing bounds PROBE to ≤52 cycles; a free slot always exists because the deck is nonempty at accept.
- DELIVER: card_valid=1 for exactly one cycle, busy=1; next state IDLE (busy=0).
- Latency: no collision gives card_valid 2 cycles after the accept edge; each collision adds 1 cycle.
- deal_req while busy is ignored with no queueing. A level-held deal_req re-accepts on the first IDLE cycle after DELIVER.
- deck_empty is combinational from cards_left. cards_left never wraps below 0.

Optional Feature:
- Macro: CARD_DEALER_STACKED_DECK_EN.
- Defined: the probe index in IDLE loads from a 6-bit sequential counter (0..51, reset/new_deck → 0, incremented per accept) instead of the LFSR. Deals are therefore deterministic in order A..K of suit 0, then suit 1, and so on. The LFSR is still present but unused. Used for controller bring-up.
- Undefined: LFSR selection as above.

Decomposition:
- Package blackjack_pkg:
  - DECK_SIZE=52, RANKS_PER_SUIT=13
  - LFSR tap positions
  - rank encodings (RANK_ACE=1, RANK_JACK..RANK_KING)
  - dealer state enum
- One sub-module, card_lfsr: LFSR with load/step and the reduced 0..51 index output.
- Decode and the used bitmap stay in card_dealer.

Test Plan:
- Full deck: reset with seed=6'd0, then 52 deal_req pulses spaced 10 cycles.
  - 52 card_valid pulses.
  - All 52 (rank,suit) pairs distinct, rank ∈1..13.
  - cards_left 51→0; deck_empty=1 after the last.
- Empty request: with deck empty, a 53rd deal_req gives deal_err high for exactly 1 cycle, no card_valid, cards_left=0.
- Latency: fresh deck, single deal_req gives card_valid exactly 2 cycles after accept; busy high those 3 cycles; deal_req pulsed while busy produces no extra card.
- Abort: new_deck asserted in the PROBE cycle gives no card_valid, cards_left=52, and the next 52 deals are again all distinct.
- Seed determinism: identical stimulus timing twice with seed=6'd5 gives identical 10-card sequences; seed=6'd6 gives a different sequence within the first 5 cards.
- Macro build: with CARD_DEALER_STACKED_DECK_EN, the first four deals are (1,0),(2,0),(3,0),(4,0); the 14th is (1,1).

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared constants, state encoding and card decode for the blackjack card dealer.
package blackjack_pkg;

    localparam int DECK_SIZE      = 52;
    localparam int RANKS_PER_SUIT = 13;

    // Fibonacci LFSR feedback taps (shift-left register)
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] RANK_JACK  = 4'd11;
    localparam logic [3:0] RANK_QUEEN = 4'd12;
    localparam logic [3:0] RANK_KING  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROBE   = 2'd1,
        ST_DELIVER = 2'd2
    } dealer_state_e;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    // Deck index 0..51 -> suit = idx/13, rank = idx%13 + 1, done with compares.
    function automatic card_t decode_card(input logic [5:0] idx);
        card_t      c;
        logic [5:0] rem;
        if (idx >= 6'(3 * RANKS_PER_SUIT)) begin
            c.suit = 2'd3;
            rem    = idx - 6'(3 * RANKS_PER_SUIT);
        end else if (idx >= 6'(2 * RANKS_PER_SUIT)) begin
            c.suit = 2'd2;
            rem    = idx - 6'(2 * RANKS_PER_SUIT);
        end else if (idx >= 6'(RANKS_PER_SUIT)) begin
            c.suit = 2'd1;
            rem    = idx - 6'(RANKS_PER_SUIT);
        end else begin
            c.suit = 2'd0;
            rem    = idx;
        end
        c.rank = 4'(rem) + RANK_ACE;
        return c;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Fibonacci LFSR seeded from the switches, with its low bits folded into a 0..51 deck index.
module card_lfsr
    import blackjack_pkg::*;
#(
    parameter int                         SEED_W   = 6,
    parameter int                         LFSR_W   = 16,
    parameter logic [LFSR_W-SEED_W-1:0]   LFSR_PAD = 10'h2B3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [SEED_W-1:0] i_seed,
    output logic [5:0]        o_idx
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;
    logic [5:0]        w_raw;

    assign w_fb = r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B] ^ r_lfsr[LFSR_TAP_C] ^ r_lfsr[LFSR_TAP_D];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_load) begin
            r_lfsr <= {i_seed, LFSR_PAD};
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    // 0..63 folds onto 0..51 with a single conditional subtract
    assign w_raw = r_lfsr[5:0];
    assign o_idx = (w_raw >= 6'(DECK_SIZE)) ? (w_raw - 6'(DECK_SIZE)) : w_raw;

endmodule

// File: rtl/card_dealer.sv
// Single-deck card dealer: picks a random unused card per request using an LFSR and linear probing.
// Build option CARD_DEALER_STACKED_DECK_EN deals cards in deck order from a counter instead.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int                         SEED_W   = 6,
    parameter int                         LFSR_W   = 16,
    parameter logic [LFSR_W-SEED_W-1:0]   LFSR_PAD = 10'h2B3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_deck,
    input  logic [SEED_W-1:0] seed,
    input  logic              deal_req,
    output logic              card_valid,
    output logic [3:0]        card_rank,
    output logic [1:0]        card_suit,
    output logic              busy,
    output logic              deal_err,
    output logic [5:0]        cards_left,
    output logic              deck_empty
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] PROBE   = ST_PROBE;
    localparam logic [1:0] DELIVER = ST_DELIVER;

    logic [1:0]           r_state;
    logic [DECK_SIZE-1:0] r_used;
    logic [5:0]           r_cards_left;
    logic [5:0]           r_probe;
    logic [3:0]           r_rank;
    logic [1:0]           r_suit;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_busy;
    logic [5:0]           w_lfsr_idx;
    logic [5:0]           w_pick;
    logic                 w_empty;
    card_t                w_card;

    card_lfsr #(
        .SEED_W   (SEED_W),
        .LFSR_W   (LFSR_W),
        .LFSR_PAD (LFSR_PAD)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (new_deck),
        .i_seed  (seed),
        .o_idx   (w_lfsr_idx)
    );

`ifdef CARD_DEALER_STACKED_DECK_EN
    logic [5:0] r_stack_cnt;

    always_ff @(posedge clk) begin
        if (!rst || new_deck) begin
            r_stack_cnt <= '0;
        end else if (r_state == IDLE && deal_req && !w_empty) begin
            r_stack_cnt <= (r_stack_cnt == 6'(DECK_SIZE - 1)) ? 6'd0 : r_stack_cnt + 6'd1;
        end
    end

    assign w_pick = r_stack_cnt;
`else
    assign w_pick = w_lfsr_idx;
`endif

    assign w_empty = (r_cards_left == 6'd0);
    assign w_card  = decode_card(r_probe);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_used       <= '0;
            r_cards_left <= 6'(DECK_SIZE);
            r_probe      <= '0;
            r_rank       <= '0;
            r_suit       <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else if (new_deck) begin
            // Aborts any deal in flight; card outputs keep the last dealt card
            r_state      <= IDLE;
            r_used       <= '0;
            r_cards_left <= 6'(DECK_SIZE);
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (deal_req) begin
                        if (w_empty) begin
                            r_err <= 1'b1;
                        end else begin
                            r_probe <= w_pick;
                            r_busy  <= 1'b1;
                            r_state <= PROBE;
                        end
                    end
                end
                PROBE: begin
                    if (!r_used[r_probe]) begin
                        r_used[r_probe] <= 1'b1;
                        r_rank          <= w_card.rank;
                        r_suit          <= w_card.suit;
                        if (!w_empty) begin
                            r_cards_left <= r_cards_left - 6'd1;
                        end
                        r_state <= DELIVER;
                    end else begin
                        r_probe <= (r_probe == 6'(DECK_SIZE - 1)) ? 6'd0 : r_probe + 6'd1;
                    end
                end
                DELIVER: begin
                    r_valid <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign card_valid = r_valid;
    assign card_rank  = r_rank;
    assign card_suit  = r_suit;
    assign busy       = r_busy;
    assign deal_err   = r_err;
    assign cards_left = r_cards_left;
    assign deck_empty = w_empty;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: deck-level reference model plus table-driven control vectors.
module tb_card_dealer;

    logic       clk;
    logic       rst;
    logic       new_deck;
    logic [5:0] seed;
    logic       deal_req;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic       busy;
    logic       deal_err;
    logic [5:0] cards_left;
    logic       deck_empty;

    card_dealer dut (
        .clk        (clk),
        .rst        (rst),
        .new_deck   (new_deck),
        .seed       (seed),
        .deal_req   (deal_req),
        .card_valid (card_valid),
        .card_rank  (card_rank),
        .card_suit  (card_suit),
        .busy       (busy),
        .deal_err   (deal_err),
        .cards_left (cards_left),
        .deck_empty (deck_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: deck contents and card count, plus the shuffle register
    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left;
    int          m_cnt;
    int          dk_r[52];
    int          dk_s[52];
    int          seq_r[3][10];
    int          seq_s[3][10];

    always @(posedge clk) begin
        if (!rst || new_deck) m_lfsr <= {seed, 10'h2B3};
        else                  m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_fresh();
        for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
        m_left = 52;
        m_cnt  = 0;
    endtask

    // Issues one request at a negedge and follows it to card_valid
    task automatic deal_one(input bit poke, output int r_o, output int s_o);
        int idx, coll, n, er, es;
`ifdef CARD_DEALER_STACKED_DECK_EN
        idx   = m_cnt;
        m_cnt = (m_cnt + 1) % 52;
`else
        idx = int'(m_lfsr[5:0]) % 52;
`endif
        coll = 0;
        while (m_used[idx]) begin
            idx = (idx + 1) % 52;
            coll++;
        end
        m_used[idx] = 1'b1;
        m_left--;
        er = idx % 13 + 1;
        es = idx / 13;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = poke;
        n = 0;
        while (card_valid !== 1'b1 && n < 80) begin
            chk("busy_in_deal", int'(busy), 1);
            @(negedge clk);
            n++;
            deal_req = 1'b0;
        end
        chk("latency", n, 2 + coll);
        chk("busy_at_valid", int'(busy), 1);
        chk("rank", int'(card_rank), er);
        chk("suit", int'(card_suit), es);
        chk("cards_left", int'(cards_left), m_left);
        r_o = int'(card_rank);
        s_o = int'(card_suit);
        @(negedge clk);
        chk("valid_one_cycle", int'(card_valid), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    task automatic run_deck(input int cnt, input int gap_lo, input int gap_hi);
        bit seen[52];
        int r, s, key;
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            deal_one(1'b0, r, s);
            dk_r[k] = r;
            dk_s[k] = s;
            chk("rank_range", int'(r >= 1 && r <= 13), 1);
            key = s * 13 + ((r >= 1 && r <= 13) ? r - 1 : 0);
            chk("distinct", int'(seen[key]), 0);
            seen[key] = 1'b1;
            repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
        end
    endtask

    task automatic seq_run(input logic [5:0] sd, input int which);
        int r, s;
        seed = sd;
        rst  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_fresh();
        for (int k = 0; k < 10; k++) begin
            deal_one(1'b0, r, s);
            seq_r[which][k] = r;
            seq_s[which][k] = s;
            repeat (3) @(negedge clk);
        end
    endtask

    typedef struct {
        bit rst_n;
        bit nd;
        bit req;
        int e_err;
        int e_busy;
        int e_valid;
        int e_left;
        int e_empty;
        int e_rank;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   r, s, differ, got_valid;

        rst = 1'b0; new_deck = 1'b0; deal_req = 1'b0; seed = 6'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_fresh();
        @(negedge clk);
        chk("rst_cards_left", int'(cards_left), 52);
        chk("rst_empty", int'(deck_empty), 0);
        chk("rst_valid", int'(card_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(deal_err), 0);
        chk("rst_rank", int'(card_rank), 0);
        chk("rst_suit", int'(card_suit), 0);

        // Full deck, one request every 10 cycles
        run_deck(52, 6, 6);
        chk("deck_empty_end", int'(deck_empty), 1);
        chk("cards_left_end", int'(cards_left), 0);
`ifdef CARD_DEALER_STACKED_DECK_EN
        for (int k = 0; k < 4; k++) begin
            chk("stack_rank", dk_r[k], k + 1);
            chk("stack_suit", dk_s[k], 0);
        end
        chk("stack14_rank", dk_r[13], 1);
        chk("stack14_suit", dk_s[13], 1);
`endif

        // Empty-deck requests, new_deck with a dropped request, then reset
        tbl[0] = '{1, 0, 1, 1, 0, 0, 0,  1, -1};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0,  1, -1};
        tbl[2] = '{1, 0, 1, 1, 0, 0, 0,  1, -1};
        tbl[3] = '{1, 1, 1, 0, 0, 0, 52, 0, -1};
        tbl[4] = '{1, 0, 0, 0, 0, 0, 52, 0, -1};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 52, 0, 0};
        for (int i = 0; i < 6; i++) begin
            rst      = tbl[i].rst_n;
            new_deck = tbl[i].nd;
            deal_req = tbl[i].req;
            @(negedge clk);
            if (!tbl[i].rst_n || tbl[i].nd) model_fresh();
            chk($sformatf("tbl%0d_err", i), int'(deal_err), tbl[i].e_err);
            chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].e_busy);
            chk($sformatf("tbl%0d_valid", i), int'(card_valid), tbl[i].e_valid);
            chk($sformatf("tbl%0d_left", i), int'(cards_left), tbl[i].e_left);
            chk($sformatf("tbl%0d_empty", i), int'(deck_empty), tbl[i].e_empty);
            if (tbl[i].e_rank >= 0) chk($sformatf("tbl%0d_rank", i), int'(card_rank), tbl[i].e_rank);
        end
        rst = 1'b1; new_deck = 1'b0; deal_req = 1'b0;
        @(negedge clk);

        // Latency with a request pulsed while busy: exactly one card results
        deal_one(1'b1, r, s);
        got_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (card_valid === 1'b1) got_valid++;
        end
        chk("no_extra_card", got_valid, 0);
        chk("left_after_one", int'(cards_left), 51);

        // Abort: new_deck sampled while the deal is probing
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
        model_fresh();
        chk("abort_busy", int'(busy), 0);
        chk("abort_left", int'(cards_left), 52);
        got_valid = 0;
        repeat (6) begin
            if (card_valid === 1'b1) got_valid++;
            @(negedge clk);
        end
        chk("abort_no_valid", got_valid, 0);
        run_deck(52, 0, 7);
        chk("abort_deck_empty", int'(deck_empty), 1);

        // Seed determinism
        seq_run(6'd5, 0);
        seq_run(6'd5, 1);
        seq_run(6'd6, 2);
        for (int k = 0; k < 10; k++) begin
            chk("seed_repeat_rank", seq_r[1][k], seq_r[0][k]);
            chk("seed_repeat_suit", seq_s[1][k], seq_s[0][k]);
        end
`ifndef CARD_DEALER_STACKED_DECK_EN
        differ = 0;
        for (int k = 0; k < 5; k++)
            if (seq_r[2][k] != seq_r[0][k] || seq_s[2][k] != seq_s[0][k]) differ = 1;
        chk("seed_differs", differ, 1);
`endif

        // Randomized seeds, deal counts and spacing
        for (int it = 0; it < 4; it++) begin
            seed = 6'($urandom);
            rst  = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            model_fresh();
            run_deck($urandom_range(20, 5), 0, 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
